fetch_queue_stage: RTL

- Parametrised successor to the single-PC fetch stage: a decoupled instruction fetch unit.
- Issues pipelined requests to instruction memory with a valid/ready handshake and keeps up to OUTSTANDING requests in flight.
- Buffers returned instructions with their PCs in a DEPTH-entry queue and delivers them to decode through a valid/ready handshake.
- Handles redirects (trap, mret, jump, fence) by flushing the queue and discarding stale in-flight responses.

---
 rtl/fetch_queue_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fetch_queue_stage.sv
// Decoupled fetch: pipelined imem requests (up to OUTSTANDING in flight) feeding a DEPTH-entry {pc, instr} queue.
// Latency: response to out_valid is 1 cycle, or 0 cycles when FETCH_BYPASS_EN is defined and the queue is empty.
// Backpressure: out_ready low holds the head; request credits (count + inflight < DEPTH) keep the queue from overflowing.
module fetch_queue_stage #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     ILEN        = 32,
    parameter int unsigned     DEPTH       = 4,
    parameter int unsigned     OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     trap,
    input  logic [XLEN-1:0]          trap_addr,
    input  logic                     mret,
    input  logic [XLEN-1:0]          mret_addr,
    input  logic                     jump,
    input  logic [XLEN-1:0]          jump_addr,
    input  logic                     fence,
    input  logic [XLEN-1:0]          fence_addr,
    output logic                     imem_valid,
    input  logic                     imem_ready,
    output logic [XLEN-1:0]          imem_addr,
    output logic                     imem_fence,
    output logic                     imem_spec,
    input  logic                     imem_rvalid,
    input  logic [ILEN-1:0]          imem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [ILEN-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic            r_run;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_discard;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic            r_pend_spec;
    logic            r_pend_fence;
    entry_t          r_mem [DEPTH];

    logic            w_redirect;
    logic            w_sel_fence;
    logic [XLEN-1:0] w_target;
    logic [CW:0]     w_credit_sum;
    logic            w_req_hs;
    logic            w_resp;
    logic            w_resp_live;
    logic            w_bypass;
    logic            w_consume;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_inflight_next;
    entry_t          w_head;

    assign w_redirect = trap | mret | jump | fence;

    always_comb begin
        w_target    = fence_addr;
        w_sel_fence = 1'b0;
        if (trap) begin
            w_target = trap_addr;
        end else if (mret) begin
            w_target = mret_addr;
        end else if (jump) begin
            w_target = jump_addr;
        end else if (fence) begin
            w_target    = fence_addr;
            w_sel_fence = 1'b1;
        end
    end

    // r_run holds requests off for the first cycle after reset release, so
    // reset is visible as imem_valid = 0 both during and at release.
    assign w_credit_sum = {1'b0, r_count} + {1'b0, r_inflight};
    assign imem_valid   = r_run && !w_redirect
                          && (r_inflight < CW'(OUTSTANDING))
                          && (w_credit_sum < (CW+1)'(DEPTH));
    assign imem_addr    = r_req_pc;
    assign imem_fence   = r_pend_fence;
    assign imem_spec    = r_pend_spec;

    assign w_req_hs = imem_valid && imem_ready;

    // A response with nothing in flight cannot belong to any live request.
    assign w_resp          = imem_rvalid && (r_inflight != '0);
    assign w_resp_live     = w_resp && !w_redirect && (r_discard == '0);
    assign w_inflight_next = r_inflight + CW'(w_req_hs) - CW'(w_resp);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_resp_live && (r_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = (r_count != '0) || w_bypass;
    assign out_pc    = w_bypass ? r_resp_pc  : w_head.pc;
    assign out_instr = w_bypass ? imem_rdata : w_head.instr;
    assign out_count = r_count;

    assign w_consume = w_bypass && out_ready;
    assign w_push    = w_resp_live && !w_consume;
    assign w_pop     = (r_count != '0) && out_ready && !w_redirect;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run        <= 1'b0;
            r_req_pc     <= RESET_PC;
            r_resp_pc    <= RESET_PC;
            r_count      <= '0;
            r_inflight   <= '0;
            r_discard    <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pend_spec  <= 1'b0;
            r_pend_fence <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_inflight <= w_inflight_next;
            if (w_redirect) begin
                // Everything still in flight, including this cycle's response, is stale.
                r_req_pc     <= w_target;
                r_resp_pc    <= w_target;
                r_discard    <= w_inflight_next;
                r_count      <= '0;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_pend_spec  <= 1'b1;
                r_pend_fence <= w_sel_fence;
            end else begin
                if (w_req_hs) begin
                    r_req_pc     <= r_req_pc + XLEN'(4);
                    r_pend_spec  <= 1'b0;
                    r_pend_fence <= 1'b0;
                end
                if (w_resp && (r_discard != '0)) begin
                    r_discard <= r_discard - CW'(1);
                end
                if (w_resp_live) begin
                    r_resp_pc <= r_resp_pc + XLEN'(4);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{pc: r_resp_pc, instr: imem_rdata};
        end
    end

endmodule
